// File: rtl/fod_cali_seq.sv
// FOD control-path sequencer: brings the DSM and phase-sync loop up, runs the
// DTC-INL calibration until the phase error stays in a lock window, watches
// for loss of lock, and applies FCW retune requests via a req/ack handshake.
module fod_cali_seq #(
    parameter int WI          = 6,
    parameter int WF          = 16,
    parameter int SETTLE_CYC  = 256,
    parameter int LOCK_THR    = 64,
    parameter int LOCK_CNT    = 32,
    parameter int UNLOCK_THR  = 256,
    parameter int TIMEOUT_CYC = 65535,
    parameter int FCW_I_MIN   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               FCW_REQ,
    input  logic [WI+WF-1:0]   FCW_NEW,
    output logic               FCW_ACK,
    output logic               FCW_ERR,
    input  logic [WF-1:0]      PHE_NORM,
    output logic [WI+WF-1:0]   FCW_FOD,
    output logic               DSM_EN,
    output logic               PSYNC_EN,
    output logic               DTCCALI_EN,
    output logic               LOCK,
    output logic               TIMEOUT,
    output logic [2:0]         STATE
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CNT - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYC);

    localparam logic [WF-1:0] THR_W   = WF'(LOCK_THR);
    localparam logic [WF-1:0] UNL_W   = WF'(UNLOCK_THR);
    localparam logic [WF-1:0] NEG_MIN = {1'b1, {(WF-1){1'b0}}};
    localparam logic [WF-1:0] POS_MAX = {1'b0, {(WF-1){1'b1}}};
    localparam logic [WI-1:0] IMIN_W  = WI'(FCW_I_MIN);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DSM_START = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_CALI      = 3'd3,
        ST_LOCKED    = 3'd4
    } state_t;

    state_t          state_reg;
    logic [SW-1:0]   settle_cnt_reg;
    logic [LW-1:0]   win_cnt_reg;
    logic [LW-1:0]   unl_cnt_reg;
    logic [TW-1:0]   to_cnt_reg;

    logic [WF-1:0]   phe_abs;
    logic            phe_in_win;
    logic            phe_out_win;
    logic            req_take;
    logic            fcw_legal;
    logic            fcw_accept;

    // |PHE_NORM| in WF bits; the most negative code saturates to the max positive.
    always_comb begin
        phe_abs = PHE_NORM;
        if (PHE_NORM == NEG_MIN) begin
            phe_abs = POS_MAX;
        end else if (PHE_NORM[WF-1]) begin
            phe_abs = (~PHE_NORM) + WF'(1);
        end
    end

    assign phe_in_win  = (phe_abs <= THR_W);
    assign phe_out_win = (phe_abs > UNL_W);

    // Requests are held off for the single DSM_START cycle; the requester keeps REQ up.
    assign req_take   = FCW_REQ && (state_reg != ST_DSM_START);
    assign fcw_legal  = (FCW_NEW[WI+WF-1:WF] >= IMIN_W);
    assign fcw_accept = req_take && fcw_legal;

    assign STATE = state_reg;

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            unl_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            FCW_FOD        <= {IMIN_W, {WF{1'b0}}};
            FCW_ACK        <= 1'b0;
            FCW_ERR        <= 1'b0;
            DSM_EN         <= 1'b0;
            PSYNC_EN       <= 1'b0;
            DTCCALI_EN     <= 1'b0;
            LOCK           <= 1'b0;
            TIMEOUT        <= 1'b0;
        end else if (!START) begin
            // Dropping START parks the sequencer; the applied FCW is retained.
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            unl_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            FCW_ACK        <= 1'b0;
            FCW_ERR        <= 1'b0;
            DSM_EN         <= 1'b0;
            PSYNC_EN       <= 1'b0;
            DTCCALI_EN     <= 1'b0;
            LOCK           <= 1'b0;
            TIMEOUT        <= 1'b0;
        end else begin
            FCW_ACK <= 1'b0;
            FCW_ERR <= 1'b0;
            if (req_take) begin
                if (fcw_legal) begin
                    FCW_FOD <= FCW_NEW;
                    FCW_ACK <= 1'b1;
                    TIMEOUT <= 1'b0;
                end else begin
                    FCW_ERR <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_DSM_START;
                    DSM_EN    <= 1'b1;
                    PSYNC_EN  <= 1'b1;
                end

                ST_DSM_START: begin
                    state_reg      <= ST_SETTLE;
                    settle_cnt_reg <= '0;
                end

                ST_SETTLE: begin
                    if (fcw_accept) begin
                        settle_cnt_reg <= '0;
                    end else if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg      <= ST_CALI;
                        DTCCALI_EN     <= 1'b1;
                        settle_cnt_reg <= '0;
                        win_cnt_reg    <= '0;
                        to_cnt_reg     <= '0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + SW'(1);
                    end
                end

                ST_CALI: begin
                    if (fcw_accept) begin
                        // A retune invalidates the calibration: settle again from scratch.
                        state_reg      <= ST_SETTLE;
                        DTCCALI_EN     <= 1'b0;
                        LOCK           <= 1'b0;
                        settle_cnt_reg <= '0;
                        win_cnt_reg    <= '0;
                        unl_cnt_reg    <= '0;
                        to_cnt_reg     <= '0;
                    end else begin
                        if (to_cnt_reg != TO_MAX) begin
                            to_cnt_reg <= to_cnt_reg + TW'(1);
                            if (to_cnt_reg == TO_LAST) begin
                                TIMEOUT <= 1'b1;
                            end
                        end
                        if (phe_in_win) begin
                            win_cnt_reg <= win_cnt_reg + LW'(1);
                            if (win_cnt_reg == LOCK_LAST) begin
                                state_reg   <= ST_LOCKED;
                                LOCK        <= 1'b1;
                                unl_cnt_reg <= '0;
                            end
                        end else begin
                            win_cnt_reg <= '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (fcw_accept) begin
                        state_reg      <= ST_SETTLE;
                        DTCCALI_EN     <= 1'b0;
                        LOCK           <= 1'b0;
                        settle_cnt_reg <= '0;
                        win_cnt_reg    <= '0;
                        unl_cnt_reg    <= '0;
                        to_cnt_reg     <= '0;
                    end else if (phe_out_win) begin
                        if (unl_cnt_reg == LOCK_LAST) begin
                            // Lock lost: resume calibration with fresh window/timeout counts.
                            state_reg   <= ST_CALI;
                            LOCK        <= 1'b0;
                            unl_cnt_reg <= '0;
                            win_cnt_reg <= '0;
                            to_cnt_reg  <= '0;
                        end else begin
                            unl_cnt_reg <= unl_cnt_reg + LW'(1);
                        end
                    end else begin
                        unl_cnt_reg <= '0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fod_cali_seq.sv
// Testbench for fod_cali_seq: start-up timing, timeout, unlock, FCW handshake
// and START/RST behaviour. FCW responses are checked through an expectation queue.
`timescale 1ns/1ps
module tb_fod_cali_seq;

    localparam int WI = 6;
    localparam int WF = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          FCW_REQ = 1'b0;
    logic [21:0]   FCW_NEW = '0;
    logic [15:0]   PHE_NORM = '0;
    logic          FCW_ACK, FCW_ERR, DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT;
    logic [21:0]   FCW_FOD;
    logic [2:0]    STATE;

    typedef struct {
        bit          is_ack;
        logic [21:0] fod;
    } exp_t;

    exp_t          exp_q[$];
    logic [21:0]   fod_model = 22'h040000;
    int            checks = 0;
    int            errors = 0;
    int            n_req = 0;
    int            resp_seen = 0;

    fod_cali_seq #(
        .WI(WI), .WF(WF), .SETTLE_CYC(8), .LOCK_THR(64), .LOCK_CNT(4),
        .UNLOCK_THR(256), .TIMEOUT_CYC(100), .FCW_I_MIN(4)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .FCW_REQ(FCW_REQ), .FCW_NEW(FCW_NEW),
        .FCW_ACK(FCW_ACK), .FCW_ERR(FCW_ERR), .PHE_NORM(PHE_NORM), .FCW_FOD(FCW_FOD),
        .DSM_EN(DSM_EN), .PSYNC_EN(PSYNC_EN), .DTCCALI_EN(DTCCALI_EN), .LOCK(LOCK),
        .TIMEOUT(TIMEOUT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Count every response pulse so stray or doubled pulses are visible at the end.
    always @(negedge CLK) begin
        if (FCW_ACK || FCW_ERR) resp_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request, push its expected response, wait for ACK/ERR and compare.
    task automatic send_req(input logic [21:0] fcw, output int lat);
        exp_t e;
        bit   got;
        e.is_ack = (fcw[21:16] >= 6'd4);
        e.fod    = e.is_ack ? fcw : fod_model;
        if (e.is_ack) fod_model = fcw;
        exp_q.push_back(e);
        n_req++;
        FCW_NEW = fcw;
        FCW_REQ = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (FCW_ACK || FCW_ERR) got = 1'b1;
        end
        FCW_REQ = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL fcw_resp_timeout: req %h got no ACK/ERR within %0d cycles, required ack=%b", fcw, lat, e.is_ack);
        end else if (FCW_ACK !== e.is_ack || FCW_ERR !== !e.is_ack || FCW_FOD !== e.fod) begin
            errors++;
            $display("FAIL fcw_resp: req %h got ack=%b err=%b fod=%h, required ack=%b err=%b fod=%h",
                     fcw, FCW_ACK, FCW_ERR, FCW_FOD, e.is_ack, !e.is_ack, e.fod);
        end
        $display("fcw req %h -> ack=%b err=%b fod=%h lat=%0d", fcw, FCW_ACK, FCW_ERR, FCW_FOD, lat);
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b1; PHE_NORM = '0; FCW_REQ = 1'b0;
        repeat (3) tick();
        checks++;
        if (STATE !== 3'd0 || FCW_FOD !== 22'h040000) begin
            errors++;
            $display("FAIL reset_state: state=%0d fod=%h, required 0 / 040000", STATE, FCW_FOD);
        end
        checks++;
        if ({DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT, FCW_ACK, FCW_ERR} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT, FCW_ACK, FCW_ERR});
        end
    endtask

    task automatic test_startup();
        logic [2:0] st;
        logic [3:0] en;
        RST = 1'b0;  // cycle 0
        for (int c = 1; c <= 14; c++) begin
            tick();
            st = (c == 1) ? 3'd1 : (c <= 9) ? 3'd2 : (c <= 13) ? 3'd3 : 3'd4;
            en = {1'b1, 1'b1, (c >= 10), (c == 14)};
            checks++;
            if (STATE !== st) begin
                errors++;
                $display("FAIL startup_state cycle %0d: got %0d, required %0d", c, STATE, st);
            end
            checks++;
            if ({DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK} !== en) begin
                errors++;
                $display("FAIL startup_en cycle %0d: got %b, required %b", c, {DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK}, en);
            end
        end
    endtask

    task automatic test_unlock();
        PHE_NORM = 16'd256;  // exactly at the unlock threshold: still in lock
        repeat (6) tick();
        checks++;
        if (LOCK !== 1'b1 || STATE !== 3'd4) begin
            errors++;
            $display("FAIL unlock_thr_edge: lock=%b state=%0d, required 1 / 4", LOCK, STATE);
        end
        PHE_NORM = 16'h8000;
        repeat (3) tick();
        PHE_NORM = 16'h0000;
        tick();
        checks++;
        if (LOCK !== 1'b1 || STATE !== 3'd4) begin
            errors++;
            $display("FAIL unlock_3plus1: lock=%b state=%0d, required 1 / 4", LOCK, STATE);
        end
        PHE_NORM = 16'h8000;
        repeat (3) tick();
        checks++;
        if (LOCK !== 1'b1 || STATE !== 3'd4) begin
            errors++;
            $display("FAIL unlock_early: lock=%b state=%0d, required 1 / 4", LOCK, STATE);
        end
        tick();
        checks++;
        if (LOCK !== 1'b0 || STATE !== 3'd3 || DTCCALI_EN !== 1'b1) begin
            errors++;
            $display("FAIL unlock_sat: lock=%b state=%0d dtc=%b, required 0 / 3 / 1", LOCK, STATE, DTCCALI_EN);
        end
        PHE_NORM = 16'hFFC0;  // -64: on the lock window boundary
        repeat (3) tick();
        checks++;
        if (STATE !== 3'd3) begin
            errors++;
            $display("FAIL relock_early: state=%0d, required 3", STATE);
        end
        tick();
        checks++;
        if (STATE !== 3'd4 || LOCK !== 1'b1) begin
            errors++;
            $display("FAIL relock_thr: state=%0d lock=%b, required 4 / 1", STATE, LOCK);
        end
        PHE_NORM = '0;
    endtask

    task automatic test_fcw_locked();
        int lat;
        send_req(22'h0A8000, lat);
        checks++;
        if (lat != 1 || LOCK !== 1'b0 || STATE !== 3'd2 || DTCCALI_EN !== 1'b0) begin
            errors++;
            $display("FAIL fcw_locked: lat=%0d lock=%b state=%0d dtc=%b, required 1 / 0 / 2 / 0", lat, LOCK, STATE, DTCCALI_EN);
        end
        tick();
        checks++;
        if (FCW_ACK !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack=%b one cycle later, required 0", FCW_ACK);
        end
        repeat (10) tick();
        checks++;
        if (STATE !== 3'd3 || LOCK !== 1'b0) begin
            errors++;
            $display("FAIL relock_pre: state=%0d lock=%b, required 3 / 0", STATE, LOCK);
        end
        tick();
        checks++;
        if (STATE !== 3'd4 || LOCK !== 1'b1) begin
            errors++;
            $display("FAIL relock_12: state=%0d lock=%b, required 4 / 1", STATE, LOCK);
        end
    endtask

    task automatic test_fcw_err_dsm();
        int lat;
        send_req(22'h030000, lat);
        checks++;
        if (lat != 1 || STATE !== 3'd4 || LOCK !== 1'b1) begin
            errors++;
            $display("FAIL fcw_err: lat=%0d state=%0d lock=%b, required 1 / 4 / 1", lat, STATE, LOCK);
        end
        START = 1'b0;
        tick();
        START = 1'b1;
        tick();
        checks++;
        if (STATE !== 3'd1) begin
            errors++;
            $display("FAIL dsm_start: state=%0d, required 1", STATE);
        end
        send_req(22'h0C0000, lat);
        checks++;
        if (lat != 2 || STATE !== 3'd2) begin
            errors++;
            $display("FAIL dsm_holdoff: lat=%0d state=%0d, required 2 / 2", lat, STATE);
        end
        repeat (7) tick();
        checks++;
        if (STATE !== 3'd2) begin
            errors++;
            $display("FAIL settle_restart: state=%0d, required 2", STATE);
        end
        tick();
        checks++;
        if (STATE !== 3'd3) begin
            errors++;
            $display("FAIL settle_end: state=%0d, required 3", STATE);
        end
    endtask

    task automatic test_timeout();
        int  n;
        logic exp_to;
        START = 1'b0;
        tick();
        START = 1'b1;
        n = 0;
        while (STATE !== 3'd3 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (STATE !== 3'd3) begin
            errors++;
            $display("FAIL cali_entry: state=%0d after %0d cycles, required 3", STATE, n);
        end
        for (int k = 0; k <= 104; k++) begin
            PHE_NORM = ((k % 4) == 3) ? 16'd500 : 16'd30;
            exp_to = (k >= 100);
            checks++;
            if (STATE !== 3'd3 || TIMEOUT !== exp_to) begin
                errors++;
                $display("FAIL timeout cali cycle %0d: state=%0d timeout=%b, required 3 / %b", k, STATE, TIMEOUT, exp_to);
            end
            tick();
        end
    endtask

    task automatic test_fcw_clears_timeout();
        int lat;
        send_req(22'h100000, lat);
        checks++;
        if (lat != 1 || TIMEOUT !== 1'b0 || STATE !== 3'd2 || DTCCALI_EN !== 1'b0) begin
            errors++;
            $display("FAIL fcw_timeout_clr: lat=%0d timeout=%b state=%0d dtc=%b, required 1 / 0 / 2 / 0", lat, TIMEOUT, STATE, DTCCALI_EN);
        end
    endtask

    task automatic test_start_low();
        START = 1'b0;
        tick();
        checks++;
        if (STATE !== 3'd0 || {DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT} !== 5'b0 || FCW_FOD !== fod_model) begin
            errors++;
            $display("FAIL start_low: state=%0d flags=%b fod=%h, required 0 / 00000 / %h",
                     STATE, {DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT}, FCW_FOD, fod_model);
        end
    endtask

    task automatic test_rst_mid();
        START = 1'b1;
        repeat (3) tick();
        checks++;
        if (STATE !== 3'd2) begin
            errors++;
            $display("FAIL pre_rst_settle: state=%0d, required 2", STATE);
        end
        RST = 1'b1;
        tick();
        fod_model = 22'h040000;
        checks++;
        if (STATE !== 3'd0 || FCW_FOD !== fod_model ||
            {DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT, FCW_ACK, FCW_ERR} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid: state=%0d fod=%h flags=%b, required 0 / 040000 / 0000000",
                     STATE, FCW_FOD, {DSM_EN, PSYNC_EN, DTCCALI_EN, LOCK, TIMEOUT, FCW_ACK, FCW_ERR});
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_unlock();
        test_fcw_locked();
        test_fcw_err_dsm();
        test_timeout();
        test_fcw_clears_timeout();
        test_timeout();
        test_start_low();
        test_rst_mid();
        repeat (2) tick();
        checks++;
        if (resp_seen != n_req || exp_q.size() != 0) begin
            errors++;
            $display("FAIL resp_count: got %0d responses (%0d queued), required %0d (0 queued)", resp_seen, exp_q.size(), n_req);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
